// File: rtl/rv64_pkg.sv
// Shared definitions for the RV64 pipeline front end.
//   NOP_INST      : canonical NOP (addi x0, x0, 0) used to fill an empty IF/ID
//   RESET_VECTOR  : default PC loaded on reset
//   S_REQ/S_WAIT/S_BUF : instruction-fetch FSM encoding
//   fetch_entry_t : {instruction, pc} pair carried between fetch and decode
package rv64_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [63:0] RESET_VECTOR = 64'h8000_0000;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_BUF  = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_resp_buf.sv
// One-entry holding buffer for a fetch response that arrived while decode was
// held. Priority: clear > load > unload.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture entry_i, buffer becomes full
//   unload_i   : release the entry, buffer becomes empty
//   clear_i    : drop the entry
//   entry_i    : {inst, pc} to capture
//   full_o     : buffer holds an entry
//   entry_o    : stored {inst, pc}
module ifu_resp_buf
    import rv64_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic         clear_i,
    input  fetch_entry_t entry_i,
    output logic         full_o,
    output fetch_entry_t entry_o
);

    logic         full_q, full_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            entry_d = entry_i;
        end else if (unload_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full_o  = full_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, issues one outstanding fetch at a time,
// honours redirect (jump) and hold from the control block, and drives the
// IF/ID register toward decode.
//   RESET_PC                     : PC loaded on reset
//   clk, rst                     : clock, synchronous active-high reset
//   jump_en_i, jump_addr_i       : redirect pulse and target (bits [1:0] ignored)
//   hold_flag_i                  : flush IF/ID and stall fetch while high
//   ifetch_req_o, ifetch_addr_o  : fetch request and address (= PC)
//   ifetch_gnt_i                 : request accepted this cycle
//   ifetch_rvalid_i, ifetch_rdata_i : response for the granted request
//   inst_o, inst_addr_o, inst_valid_o : IF/ID register toward decode
// Optional macro IFU_PERF_CNT_EN adds perf_fetch_cnt_o (delivered
// instructions) and perf_flush_cnt_o (dropped responses plus buffer clears).
//
// Handshake: a request transfers in a cycle where ifetch_req_o and
// ifetch_gnt_i are both high; exactly one ifetch_rvalid_i follows, at least
// one cycle later, and no new request is raised until it has been consumed.
module ifu_fetch
    import rv64_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [63:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ifetch_req_o,
    output logic [63:0] ifetch_addr_o,
    input  logic        ifetch_gnt_i,
    input  logic        ifetch_rvalid_i,
    input  logic [31:0] ifetch_rdata_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_o,
    output logic        inst_valid_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [63:0] perf_flush_cnt_o
`endif
);

    logic [1:0]   state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  pend_pc_q, pend_pc_d;
    logic         discard_q, discard_d;
    logic [31:0]  inst_q, inst_d;
    logic [63:0]  inst_addr_q, inst_addr_d;
    logic         inst_valid_q, inst_valid_d;

    logic         grant;
    logic         buf_load, buf_unload, buf_clear, buf_full;
    fetch_entry_t buf_in, buf_out;

    assign ifetch_req_o  = (state_q == S_REQ) && !hold_flag_i;
    assign ifetch_addr_o = pc_q;
    assign grant         = ifetch_req_o && ifetch_gnt_i;
    assign buf_in        = {ifetch_rdata_i, pend_pc_q};
    assign buf_clear     = jump_en_i && buf_full;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        discard_d    = discard_q;
        inst_d       = NOP_INST;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = 1'b0;
        buf_load     = 1'b0;
        buf_unload   = 1'b0;

        if (jump_en_i) begin
            pc_d = jump_addr_i & ~64'h3;
            case (state_q)
                S_REQ: begin
                    // The old-PC request was accepted anyway; its response must be eaten.
                    if (grant) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifetch_rvalid_i) begin
                        // Response is here now, so nothing is left to discard.
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (grant) begin
                        pend_pc_d = pc_q;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifetch_rvalid_i) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (hold_flag_i) begin
                            buf_load = 1'b1;
                            state_d  = S_BUF;
                        end else begin
                            inst_d       = ifetch_rdata_i;
                            inst_addr_d  = pend_pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + 64'd4;
                            state_d      = S_REQ;
                        end
                    end
                end
                S_BUF: begin
                    if (!hold_flag_i) begin
                        buf_unload   = 1'b1;
                        inst_d       = buf_out.inst;
                        inst_addr_d  = buf_out.pc;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 64'd4;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            discard_q    <= 1'b0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            discard_q    <= discard_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    ifu_resp_buf u_resp_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .clear_i  (buf_clear),
        .entry_i  (buf_in),
        .full_o   (buf_full),
        .entry_o  (buf_out)
    );

    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [63:0] perf_flush_cnt_q, perf_flush_cnt_d;
    logic        resp_dropped;

    // A response is thrown away when it was already marked stale or a jump lands with it.
    assign resp_dropped = (state_q == S_WAIT) && ifetch_rvalid_i && (discard_q || jump_en_i);

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + 64'(inst_valid_d);
        perf_flush_cnt_d = perf_flush_cnt_q + 64'(resp_dropped) + 64'(buf_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_cnt_q;
    assign perf_flush_cnt_o = perf_flush_cnt_q;
`endif

`ifndef SYNTHESIS
    // Responses outside S_WAIT are ignored by the FSM; flag them in simulation.
    rvalid_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        ifetch_rvalid_i |-> (state_q == S_WAIT));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a randomised memory, redirect and hold driver checked
// against a transaction-level model of the fetch stream (program order,
// outstanding request, parked response, stale responses after a redirect).
module tb_ifu_fetch;
    import rv64_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic        hold_flag_i;
    logic        ifetch_req_o;
    logic [63:0] ifetch_addr_o;
    logic        ifetch_gnt_i;
    logic        ifetch_rvalid_i;
    logic [31:0] ifetch_rdata_i;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;
    logic        inst_valid_o;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_o;
    logic [63:0] perf_flush_cnt_o;
    longint unsigned delivered_cnt;
    longint unsigned flush_cnt;
`endif

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_i     (hold_flag_i),
        .ifetch_req_o    (ifetch_req_o),
        .ifetch_addr_o   (ifetch_addr_o),
        .ifetch_gnt_i    (ifetch_gnt_i),
        .ifetch_rvalid_i (ifetch_rvalid_i),
        .ifetch_rdata_i  (ifetch_rdata_i),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .inst_valid_o    (inst_valid_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];   // addresses of instructions due at decode next cycle

    logic [63:0] exp_pc;      // next instruction in program order (= fetch PC)
    logic [63:0] req_addr;    // program address of the outstanding request
    logic [63:0] mem_addr;    // address memory actually saw for it
    logic [63:0] buf_addr;    // program address of the parked response
    bit          outstanding;
    bit          stale;
    bit          buffered;
    bit          exp_valid;
    int          lat;
    int          hold_left;

    int          gnt_pct, jump_pct, hold_pct, lat_max;
    bit          force_jump;
    logic [63:0] force_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RST_PC) return 32'h0010_0093;
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] pick_target();
        case ($urandom_range(0, 3))
            0: return {$urandom(), $urandom()};
            1: return 64'h8000_0100 + 64'($urandom_range(0, 255));
            2: return 64'hFFFF_FFFF_FFFF_FFF4 + 64'($urandom_range(0, 11));
            default: return RST_PC + 64'($urandom_range(0, 64));
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_pc      = RST_PC;
        req_addr    = '0;
        mem_addr    = '0;
        buf_addr    = '0;
        outstanding = 0;
        stale       = 0;
        buffered    = 0;
        exp_valid   = 0;
        lat         = 0;
        hold_left   = 0;
        force_jump  = 0;
`ifdef IFU_PERF_CNT_EN
        delivered_cnt = 0;
        flush_cnt     = 0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst             = 1'b1;
        jump_en_i       = 1'b0;
        jump_addr_i     = '0;
        hold_flag_i     = 1'b0;
        ifetch_gnt_i    = 1'b0;
        ifetch_rvalid_i = 1'b0;
        ifetch_rdata_i  = '0;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst_inst", 64'(inst_o), 64'(NOP_INST));
        check("rst_iaddr", inst_addr_o, 64'd0);
        check("rst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_pc", ifetch_addr_o, RST_PC);
        check("rst_req", 64'(ifetch_req_o), 64'd1);
        rst = 1'b0;
    endtask

    // One clock: drive inputs just after a falling edge, check the combinational
    // request, advance the model for the coming rising edge, then check the
    // registered outputs at the next falling edge.
    task automatic run_cycle();
        bit   jmp, hld, rv, grant, deliver;
        logic [63:0] del_addr;

        if (hold_left > 0) begin
            hld = 1;
            hold_left--;
        end else if (int'($urandom_range(0, 99)) < hold_pct) begin
            hld = 1;
            hold_left = int'($urandom_range(0, 4));
        end else begin
            hld = 0;
        end
        jmp = force_jump || (int'($urandom_range(0, 99)) < jump_pct);
        jump_addr_i = force_jump ? force_addr : pick_target();
        force_jump = 0;

        rv = 0;
        if (outstanding) begin
            if (lat == 0) rv = 1;
            else lat--;
        end

        hold_flag_i     = hld;
        jump_en_i       = jmp;
        ifetch_rvalid_i = rv;
        ifetch_rdata_i  = rv ? mem_word(mem_addr) : $urandom();
        ifetch_gnt_i    = (int'($urandom_range(0, 99)) < gnt_pct);
        #1;
        check("req", 64'(ifetch_req_o), 64'(!outstanding && !buffered && !hld));
        check("pc", ifetch_addr_o, exp_pc);
        grant = ifetch_req_o && ifetch_gnt_i;

        deliver  = 0;
        del_addr = '0;
`ifdef IFU_PERF_CNT_EN
        if (jmp && buffered) flush_cnt++;
        if (rv && (stale || jmp)) flush_cnt++;
`endif
        if (rv) begin
            outstanding = 0;
            if (!stale && !jmp) begin
                if (hld) begin
                    buffered = 1;
                    buf_addr = req_addr;
                end else begin
                    deliver  = 1;
                    del_addr = req_addr;
                end
            end
        end else if (buffered && !hld && !jmp) begin
            deliver  = 1;
            del_addr = buf_addr;
            buffered = 0;
        end
        if (jmp) begin
            buffered = 0;
            if (outstanding) stale = 1;
        end
        if (grant) begin
            outstanding = 1;
            stale       = jmp;
            req_addr    = exp_pc;
            mem_addr    = ifetch_addr_o;
            lat         = int'($urandom_range(0, lat_max));
        end
        if (jmp) exp_pc = jump_addr_i & ~64'h3;
        else if (deliver) exp_pc = exp_pc + 64'd4;
        exp_valid = deliver;
        if (deliver) begin
            exp_q.push_back(del_addr);
`ifdef IFU_PERF_CNT_EN
            delivered_cnt++;
`endif
        end

        @(negedge clk);
        check("valid", 64'(inst_valid_o), 64'(exp_valid));
        if (exp_valid && exp_q.size() > 0) begin
            logic [63:0] a;
            a = exp_q.pop_front();
            check("iaddr", inst_addr_o, a);
            check("inst", 64'(inst_o), 64'(mem_word(a)));
        end else begin
            check("nop", 64'(inst_o), 64'(NOP_INST));
        end
    endtask

    task automatic set_knobs(input int g, input int j, input int h, input int l);
        gnt_pct  = g;
        jump_pct = j;
        hold_pct = h;
        lat_max  = l;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_knobs(100, 0, 0, 0);
        do_reset();

        // Back-to-back fetches from the reset vector with 1-cycle memory.
        repeat (8) run_cycle();

        // Redirect near the top of the address space to exercise PC wrap.
        force_jump = 1;
        force_addr = 64'hFFFF_FFFF_FFFF_FFFE;
        repeat (12) run_cycle();

        // Hold across an outstanding response.
        force_jump = 1;
        force_addr = 64'h8000_0010;
        run_cycle();
        run_cycle();
        hold_left = 4;
        set_knobs(100, 0, 0, 2);
        repeat (10) run_cycle();

        // Mixed random traffic.
        set_knobs(60, 6, 8, 3);
        repeat (1500) run_cycle();

        // Reset in the middle of traffic, then hold-heavy traffic.
        do_reset();
        set_knobs(80, 4, 25, 1);
        repeat (800) run_cycle();

`ifdef IFU_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt_o, 64'(delivered_cnt));
        check("perf_flush", perf_flush_cnt_o, 64'(flush_cnt));
`endif

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit for the RV64 pipeline and the consumer of the pipeline control outputs. It holds the PC, issues single-outstanding fetch requests to instruction memory, and honours redirect (`jump_en_i`/`jump_addr_i`) and flush/stall (`hold_flag_i`) from the control block. Fetched instructions go into the IF/ID register toward decode. It sits between the control block and memory on one side and the decode stage on the other.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC loaded on reset.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `jump_en_i`  input  1  redirect request from control; 1-cycle pulse.
- `jump_addr_i`  input  64  redirect target; bits [1:0] are forced to 0.
- `hold_flag_i`  input  1  flush IF/ID and stall fetch while high.
- `ifetch_req_o`  output  1  fetch request valid.
- `ifetch_addr_o`  output  64  fetch address, equal to the current PC.
- `ifetch_gnt_i`  input  1  memory accepts the request this cycle when high with `ifetch_req_o`.
- `ifetch_rvalid_i`  input  1  response valid; at most one per granted request, arriving 1 or more cycles after grant.
- `ifetch_rdata_i`  input  32  fetched instruction.
- `inst_o`  output  32  instruction to decode; NOP (32'h0000_0013) when invalid.
- `inst_addr_o`  output  64  PC of `inst_o`.
- `inst_valid_o`  output  1  `inst_o` is valid this cycle.

## Operation
- State machine with three states:
  - **S_REQ**: drives `ifetch_req_o = !hold_flag_i`. On grant, the PC is latched as `pend_pc` and the state moves to S_WAIT.
  - **S_WAIT**: waits for `ifetch_rvalid_i`.
  - **S_BUF**: a response is parked in the 1-entry buffer.
- S_WAIT, on rvalid:
  - `discard` set: drop the data, clear `discard`, go to S_REQ.
  - Else if `hold_flag_i`: store {rdata, pend_pc} in the buffer, go to S_BUF.
  - Else: load IF/ID with {rdata, pend_pc, valid = 1}, PC += 4, go to S_REQ.
- S_BUF, when `hold_flag_i` is low: move the buffer into IF/ID with valid = 1, PC += 4, go to S_REQ.
- Jump (highest priority, any state):
  - PC <= `jump_addr_i` with bits [1:0] cleared.
  - IF/ID is flushed to NOP with valid = 0.
  - Buffer is cleared.
  - In S_WAIT, or in S_REQ when the grant lands in the same cycle: set `discard` and go to (or stay in) S_WAIT.
  - In S_REQ without grant: stay in S_REQ. The request address may change before grant.
  - In S_BUF: go to S_REQ.
- Hold without jump:
  - IF/ID is flushed to NOP with valid = 0.
  - PC is frozen.
  - No new request is issued; an outstanding response is buffered, not lost.
- When no instruction is delivered in a cycle, IF/ID is NOP with valid = 0. `inst_valid_o` is a 1-cycle pulse per instruction.
- PC arithmetic is 64-bit unsigned and wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- A response in S_REQ, or in S_BUF, is a protocol violation: ignored, with an assertion in simulation.

## Timing
- Reset values:
  - PC = RESET_PC, state = S_REQ, `discard` = 0, buffer empty.
  - `inst_o` = NOP, `inst_addr_o` = 0, `inst_valid_o` = 0.
  - `ifetch_req_o` = 1 in the first cycle after reset deasserts.
- Reset mid-fetch abandons the outstanding request. Memory is reset by the same `rst`, so no stale response is expected.
- Latency: rvalid in cycle t gives `inst_valid_o` in cycle t+1.
- Grant in cycle t gives the next request at the earliest in cycle t+2 (best throughput: 1 instruction per 2 cycles with 1-cycle memory).
- Jump in cycle t: `ifetch_addr_o` = target in cycle t+1, and `inst_valid_o` = 0 in cycle t+1.
- Jump and hold together: the jump wins.
- Jump and rvalid together: the response is dropped.
- Jump and grant together: the granted response is discarded.
- Hold released in cycle t with the buffer full: buffered instruction is valid in cycle t+1.
- `ifetch_addr_o` is combinational from the PC register. `inst_*` are registered.

## Configuration
- `IFU_PERF_CNT_EN` defined: adds two outputs, both cleared by `rst`:
  - `perf_fetch_cnt_o` [63:0]: counts delivered instructions.
  - `perf_flush_cnt_o` [63:0]: counts jump-discarded responses plus buffer clears.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `rv64_pkg` holds:
  - the NOP constant 32'h0000_0013,
  - the IFU state encoding (S_REQ, S_WAIT, S_BUF),
  - the default reset vector constant.
- One sub-module, `ifu_resp_buf`: 1-entry {inst, pc} holding buffer with load, unload and clear, plus a full flag.

## Test plan
- Reset release, memory grants immediately and gives rvalid 1 cycle later with 32'h0010_0093:
  - request at 8000_0000, then `inst_o` = 0010_0093, `inst_addr_o` = 8000_0000, valid for 1 cycle;
  - next request at 8000_0004.
- Jump to 8000_0100 in the cycle rvalid arrives for 8000_0008: response dropped, next request at 8000_0100, no valid output for 8000_0008.
- Jump issued while in S_WAIT, rvalid arrives 3 cycles later: data discarded, next request at the target, `discard` cleared.
- Hold high for 4 cycles across rvalid of 8000_0010:
  - no requests during the hold, `inst_o` = NOP;
  - instruction valid in the cycle after hold drops, PC then 8000_0014.
- Jump and hold in the same cycle while S_BUF holds data: buffer cleared, request at the jump target in the next cycle.
- Jump to 64'hFFFF_FFFF_FFFF_FFFE: request at FFFF_FFFF_FFFF_FFFC; after its delivery, next request at 0.
